aes_uart_frame_ctrl: RTL

Command/frame sequencer between the UART byte link and the AES core in the DRAM SCA test top.
- Parses host frames (header + 16 key bytes + 16 plaintext bytes).
- Loads the AES core and pulses its start, then waits for done.
- Streams the 16-byte ciphertext back to the UART TX, driving the board BSY indicator throughout.

---
 rtl/aes_frame_pkg.sv | 16 +
 rtl/byte_shreg128.sv | 30 +++
 rtl/aes_uart_frame_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/aes_frame_pkg.sv
// Shared types and constants for the UART <-> AES frame sequencer.
package aes_frame_pkg;
  localparam int         AES_BYTES       = 16;
  localparam logic [7:0] HDR_ENC_DEFAULT = 8'h01;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    IDLE,
    RX_KEY,
    RX_PT,
    START,
    WAIT,
    TX
  } state_e;
endpackage

// File: rtl/byte_shreg128.sv
// 128-bit byte-wise shift register: parallel load, shift-in byte at the LSB end,
// or shift-out (MSB byte leaves, zero enters). Priority: load > shift_in > shift_out.
module byte_shreg128
  import aes_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  block_t     load_data,
  input  logic       shift_in,
  input  logic [7:0] din,
  input  logic       shift_out,
  output block_t     q
);
  block_t data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load)           data_d = load_data;
    else if (shift_in)  data_d = {data_q[119:0], din};
    else if (shift_out) data_d = {data_q[119:0], 8'h00};
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;
endmodule

// File: rtl/aes_uart_frame_ctrl.sv
// Frame sequencer: header + 16 key + 16 pt bytes from UART, run AES, stream 16 ct bytes back.
// Optional SCA_TRIG_EN adds sca_trig, high from START through WAIT (scope trigger).
module aes_uart_frame_ctrl
  import aes_frame_pkg::*;
#(
  parameter logic [7:0] HDR_ENC        = HDR_ENC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [127:0] aes_key,
  output logic [127:0] aes_pt,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_ct,
  output logic         bsy,
  output logic         frame_err
`ifdef SCA_TRIG_EN
  ,
  output logic         sca_trig
`endif
);
  localparam logic [4:0]      LAST_BYTE = 5'(AES_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_inc;
  logic            tx_valid_q, tx_valid_d;
  logic            bsy_q, bsy_d;
  logic            aes_start_q, aes_start_d;
  logic            frame_err_q, frame_err_d;
`ifdef SCA_TRIG_EN
  logic            sca_trig_q, sca_trig_d;
`endif

  logic            key_sh, pt_sh, ct_ld, ct_sh;
  block_t          ct_q;
  logic [119:0]    ct_lo_unused;

  assign to_inc = to_cnt_q + TO_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_cnt_d    = '0;
    frame_err_d = 1'b0;
    key_sh      = 1'b0;
    pt_sh       = 1'b0;
    ct_ld       = 1'b0;
    ct_sh       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == HDR_ENC) begin
            state_d = RX_KEY;
            cnt_d   = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      RX_KEY, RX_PT: begin
        // An arriving byte always beats a timeout expiring in the same cycle.
        if (rx_valid) begin
          key_sh = (state_q == RX_KEY);
          pt_sh  = (state_q == RX_PT);
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = (state_q == RX_KEY) ? RX_PT : START;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else if (to_inc == TO_LIMIT) begin
          state_d     = IDLE;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      START: begin
        frame_err_d = rx_valid;
        state_d     = WAIT;
      end
      WAIT: begin
        frame_err_d = rx_valid;
        if (aes_done) begin
          ct_ld   = 1'b1;
          cnt_d   = '0;
          state_d = TX;
        end
      end
      TX: begin
        frame_err_d = rx_valid;
        if (tx_valid_q && tx_ready) begin
          ct_sh = 1'b1;
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_valid_d  = (state_d == TX);
    bsy_d       = (state_d != IDLE);
    aes_start_d = (state_d == START);
`ifdef SCA_TRIG_EN
    sca_trig_d  = (state_d == START) || (state_d == WAIT);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      tx_valid_q  <= 1'b0;
      bsy_q       <= 1'b0;
      aes_start_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SCA_TRIG_EN
      sca_trig_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      tx_valid_q  <= tx_valid_d;
      bsy_q       <= bsy_d;
      aes_start_q <= aes_start_d;
      frame_err_q <= frame_err_d;
`ifdef SCA_TRIG_EN
      sca_trig_q  <= sca_trig_d;
`endif
    end
  end

  byte_shreg128 u_key (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift_in(key_sh), .din(rx_data), .shift_out(1'b0), .q(aes_key)
  );

  byte_shreg128 u_pt (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .shift_in(pt_sh), .din(rx_data), .shift_out(1'b0), .q(aes_pt)
  );

  byte_shreg128 u_ct (
    .clk(clk), .rst(rst), .load(ct_ld), .load_data(aes_ct),
    .shift_in(1'b0), .din(8'h00), .shift_out(ct_sh), .q(ct_q)
  );

  // Only the MSB byte of the ct register is ever presented.
  assign {tx_data, ct_lo_unused} = ct_q;

  assign tx_valid  = tx_valid_q;
  assign bsy       = bsy_q;
  assign aes_start = aes_start_q;
  assign frame_err = frame_err_q;
`ifdef SCA_TRIG_EN
  assign sca_trig  = sca_trig_q;
`endif
endmodule
